idvdebug_osc_meas: RTL and testbench

IDVDEBUG_OSC_MEAS -- requirements
Module: idvdebug_osc_meas

---
 rtl/idvdebug_pkg.sv | 25 ++
 rtl/idvdebug_sync_edge.sv | 27 ++
 rtl/idvdebug_osc_meas.sv | 142 ++++++++++++++
 tb/tb_idvdebug_osc_meas.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/idvdebug_pkg.sv
// Shared types and defaults for the IDV debug oscillator frequency measurement block.
package idvdebug_pkg;

  localparam int CNT_W_DEF       = 16;
  localparam int WAKE_CYC_DEF    = 4;
  localparam int SYNC_STAGES_DEF = 2;

  typedef logic [5:0] osc_idx_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAKE,
    ST_SETTLE,
    ST_MEASURE,
    ST_DONE
  } meas_state_t;

  // Bit idx of the bank enable vector; index 0 has no oscillator behind it.
  function automatic logic [63:1] osc_onehot(input osc_idx_t idx);
    logic [63:0] full;
    full = 64'd1 << idx;
    return full[63:1];
  endfunction

endpackage

// File: rtl/idvdebug_sync_edge.sv
// Multi-flop synchronizer for the asynchronous oscillator bank output plus rising-edge detect.
module idvdebug_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  logic [STAGES-1:0] sync_q;
  logic              last_q;

  // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_in};
      last_q <= sync_q[STAGES-1];
    end
  end

  assign rise = sync_q[STAGES-1] & ~last_q;

endmodule

// File: rtl/idvdebug_osc_meas.sv
// Oscillator frequency measurement: wakes the bank, enables one oscillator, settles,
// then counts synchronized rising edges of hfbankl over a programmable window.
module idvdebug_osc_meas
  import idvdebug_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int WAKE_CYC    = WAKE_CYC_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             idvdebug_clki,
  input  logic             idvdebug_rst,
  input  logic             start,
  input  logic             abort,
  input  logic [5:0]       osc_sel,
  input  logic [7:0]       settle_len,
  input  logic [15:0]      win_len,
  input  logic             hfbankl,
  output logic [63:1]      enosc,
  output logic             sleep_b,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             ovf,
  output logic             err
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  meas_state_t      state_q, state_d;
  logic [15:0]      tmr_q, tmr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_run_q, ovf_run_d;
  osc_idx_t         osc_q;
  logic [7:0]       settle_q;
  logic [15:0]      win_q;
  logic             accept, reject, rise;

  idvdebug_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_edge (
    .clk      (idvdebug_clki),
    .rst      (idvdebug_rst),
    .async_in (hfbankl),
    .rise     (rise)
  );

  // NOTE: every variable gets a default first so no path through the block can infer a latch.
  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    cnt_d     = cnt_q;
    ovf_run_d = ovf_run_q;
    accept    = 1'b0;
    reject    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (osc_sel != '0 && win_len != '0) begin
            accept  = 1'b1;
            state_d = ST_WAKE;
            tmr_d   = 16'(WAKE_CYC - 1);
          end else begin
            reject = 1'b1;
          end
        end
      end
      ST_WAKE: begin
        if (tmr_q != '0) begin
          tmr_d = tmr_q - 16'd1;
        end else if (settle_q == '0) begin
          state_d = ST_MEASURE;
          tmr_d   = win_q - 16'd1;
        end else begin
          state_d = ST_SETTLE;
          tmr_d   = {8'd0, settle_q} - 16'd1;
        end
      end
      ST_SETTLE: begin
        if (tmr_q != '0) begin
          tmr_d = tmr_q - 16'd1;
        end else begin
          state_d = ST_MEASURE;
          tmr_d   = win_q - 16'd1;
        end
      end
      ST_MEASURE: begin
        // Saturate rather than wrap; ovf records that an edge arrived with no room left.
        if (rise) begin
          if (cnt_q == '1) ovf_run_d = 1'b1;
          else             cnt_d     = cnt_q + CNT_ONE;
        end
        if (tmr_q != '0) tmr_d   = tmr_q - 16'd1;
        else             state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (state_q != ST_MEASURE && state_d == ST_MEASURE) begin
      cnt_d     = '0;
      ovf_run_d = 1'b0;
    end
    if (abort && state_q != ST_IDLE) state_d = ST_IDLE;
  end

  always_ff @(posedge idvdebug_clki) begin
    if (idvdebug_rst) begin
      state_q   <= ST_IDLE;
      tmr_q     <= '0;
      cnt_q     <= '0;
      ovf_run_q <= 1'b0;
      osc_q     <= '0;
      settle_q  <= '0;
      win_q     <= '0;
      enosc     <= '0;
      count     <= '0;
      ovf       <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      cnt_q     <= cnt_d;
      ovf_run_q <= ovf_run_d;
      if (accept) begin
        osc_q    <= osc_sel;
        settle_q <= settle_len;
        win_q    <= win_len;
        err      <= 1'b0;
      end
      if (reject) err <= 1'b1;
      // Registered decode, aligned with the state it belongs to.
      enosc <= (state_d == ST_SETTLE || state_d == ST_MEASURE) ? osc_onehot(osc_q) : '0;
      if (state_q == ST_MEASURE && state_d == ST_DONE) begin
        count <= cnt_d;
        ovf   <= ovf_run_d;
      end
    end
  end

  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_DONE);
  assign sleep_b = (state_q == ST_WAKE) || (state_q == ST_SETTLE) || (state_q == ST_MEASURE);

endmodule

// File: tb/tb_idvdebug_osc_meas.sv
// Self-checking bench for idvdebug_osc_meas: table-driven measurements with a result
// scoreboard, plus hand-written reject, abort and reset sequences.
module tb_idvdebug_osc_meas;

  localparam int WAKE = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [5:0]  osc_sel = '0;
  logic [7:0]  settle_len = '0;
  logic [15:0] win_len = '0;
  logic        hfbankl = 1'b0;

  logic [63:1] enosc, enosc8;
  logic        sleep_b, busy, done, ovf, err;
  logic        sleep_b8, busy8, done8, ovf8, err8;
  logic [15:0] count;
  logic [7:0]  count8;

  idvdebug_osc_meas dut (
    .idvdebug_clki(clk), .idvdebug_rst(rst), .start(start), .abort(abort),
    .osc_sel(osc_sel), .settle_len(settle_len), .win_len(win_len), .hfbankl(hfbankl),
    .enosc(enosc), .sleep_b(sleep_b), .busy(busy), .done(done),
    .count(count), .ovf(ovf), .err(err)
  );

  idvdebug_osc_meas #(.CNT_W(8)) dut8 (
    .idvdebug_clki(clk), .idvdebug_rst(rst), .start(start), .abort(abort),
    .osc_sel(osc_sel), .settle_len(settle_len), .win_len(win_len), .hfbankl(hfbankl),
    .enosc(enosc8), .sleep_b(sleep_b8), .busy(busy8), .done(done8),
    .count(count8), .ovf(ovf8), .err(err8)
  );

  always #5 clk = ~clk;

  // Oscillator model: period in clocks (0 = hold hf_lvl).
  int   hf_per = 0;
  logic hf_lvl = 1'b0;
  int   hf_ph  = 0;
  always @(negedge clk) begin
    if (hf_per == 0) begin
      hfbankl = hf_lvl;
    end else begin
      hf_ph = hf_ph + 1;
      if (hf_ph >= hf_per / 2) begin
        hf_ph   = 0;
        hfbankl = ~hfbankl;
      end
    end
  end

  typedef struct {
    logic [5:0]  osc;
    logic [7:0]  settle;
    logic [15:0] win;
    int          hf_per;
    logic        hf_lvl;
    int          poke_k;
    int          exp_cnt;
    logic        exp_ovf;
    int          exp_cnt8;
    logic        exp_ovf8;
  } vec_t;

  typedef struct {
    int   lat;
    int   cnt;
    logic ovf;
    int   cnt8;
    logic ovf8;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[6];
  int   total = 0;
  int   bad = 0;
  int   last_cnt = 0;
  logic last_ovf = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:1] model_onehot(input logic [5:0] idx);
    logic [63:1] v;
    v = '0;
    for (int i = 1; i < 64; i++) if (i == int'(idx)) v[i] = 1'b1;
    return v;
  endfunction

  task automatic run_row(input vec_t v, input string tag);
    exp_t        e, got;
    int          k, lat;
    bit          seen, seq_ok;
    logic [63:1] oh, exp_en;
    hf_per = v.hf_per;
    hf_lvl = v.hf_lvl;
    repeat (8) @(negedge clk);
    lat    = 1 + WAKE + int'(v.settle) + int'(v.win);
    e.lat  = lat;  e.cnt  = v.exp_cnt;  e.ovf  = v.exp_ovf;
    e.cnt8 = v.exp_cnt8; e.ovf8 = v.exp_ovf8;
    sb.push_back(e);
    oh = model_onehot(v.osc);
    osc_sel = v.osc; settle_len = v.settle; win_len = v.win; start = 1'b1;
    @(negedge clk);
    start = 1'b0; k = 1; seen = 1'b0; seq_ok = 1'b1;
    while (!seen && k <= lat + 20) begin
      exp_en = (k > WAKE && k <= lat - 1) ? oh : '0;
      if (sleep_b !== (k <= lat - 1) || enosc !== exp_en || done !== (k == lat) ||
          busy !== (k <= lat) || done8 !== done || err !== 1'b0)
        seq_ok = 1'b0;
      if (done === 1'b1) begin
        seen = 1'b1;
      end else begin
        start = (k == v.poke_k);
        if (start) osc_sel = 6'd40;
        @(negedge clk);
        start = 1'b0; osc_sel = v.osc; k++;
      end
    end
    got = sb.pop_front();
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    check({tag, "_latency"}, 64'(k), 64'(got.lat));
    check({tag, "_sequence"}, 64'(seq_ok), 64'd1);
    check({tag, "_count"}, 64'(count), 64'(got.cnt));
    check({tag, "_ovf"}, 64'(ovf), 64'(got.ovf));
    check({tag, "_count8"}, 64'(count8), 64'(got.cnt8));
    check({tag, "_ovf8"}, 64'(ovf8), 64'(got.ovf8));
    last_cnt = got.cnt;
    last_ovf = got.ovf;
    @(negedge clk);
    check({tag, "_idle_after"}, {62'd0, busy, done}, 64'd0);
  endtask

  task automatic start_run(input logic [5:0] osc, input logic [7:0] st, input logic [15:0] win);
    osc_sel = osc; settle_len = st; win_len = win; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    bit quiet;
    //           osc    settle  win      per lvl poke cnt  ovf cnt8 ovf8
    vecs[0] = '{6'd5,  8'd2, 16'd40,  4, 1'b0, 0,  10, 1'b0, 10, 1'b0};
    vecs[1] = '{6'd63, 8'd0, 16'd20,  0, 1'b1, 0,   0, 1'b0,  0, 1'b0};
    vecs[2] = '{6'd1,  8'd3, 16'd600, 2, 1'b0, 0, 300, 1'b0, 255, 1'b1};
    vecs[3] = '{6'd33, 8'd1, 16'd12,  4, 1'b0, 0,   3, 1'b0,  3, 1'b0};
    vecs[4] = '{6'd2,  8'd0, 16'd32,  4, 1'b0, 15,  8, 1'b0,  8, 1'b0};
    vecs[5] = '{6'd20, 8'd5, 16'd18,  6, 1'b0, 0,   3, 1'b0,  3, 1'b0};

    repeat (3) @(negedge clk);
    check("reset_enosc", 64'(enosc), 64'd0);
    check("reset_sleep_b", 64'(sleep_b), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_count", 64'(count), 64'd0);
    check("reset_ovf", 64'(ovf), 64'd0);
    check("reset_err", 64'(err), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_row(vecs[i], $sformatf("row%0d", i));

    // Rejected starts: illegal osc_sel, then zero window.
    start_run(6'd0, 8'd1, 16'd10);
    check("rej_osc_err", 64'(err), 64'd1);
    check("rej_osc_state", {61'd0, busy, sleep_b, done}, 64'd0);
    check("rej_osc_enosc", 64'(enosc), 64'd0);
    check("rej_osc_count", 64'(count), 64'(last_cnt));
    start_run(6'd3, 8'd1, 16'd0);
    @(negedge clk);
    check("rej_win_err", 64'(err), 64'd1);
    check("rej_win_state", {61'd0, busy, sleep_b, done}, 64'd0);
    check("rej_win_enosc", 64'(enosc), 64'd0);
    check("rej_win_ovf", 64'(ovf), 64'(last_ovf));

    // Abort inside MEASURE (cycles 6..55 for settle 1, win 50).
    hf_per = 4;
    start_run(6'd9, 8'd1, 16'd50);
    check("accept_clears_err", 64'(err), 64'd0);
    repeat (9) @(negedge clk);
    check("abort_pre_enosc", 64'(enosc), 64'(model_onehot(6'd9)));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_state", {61'd0, busy, sleep_b, done}, 64'd0);
    check("abort_enosc", 64'(enosc), 64'd0);
    check("abort_count_held", 64'(count), 64'(last_cnt));
    check("abort_ovf_held", 64'(ovf), 64'(last_ovf));
    quiet = 1'b1;
    repeat (60) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    check("abort_no_done", 64'(quiet), 64'd1);

    // Reset inside MEASURE, with abort and start also raised.
    start_run(6'd12, 8'd0, 16'd40);
    repeat (9) @(negedge clk);
    rst = 1'b1; abort = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; abort = 1'b0; start = 1'b0;
    check("rst_state", {61'd0, busy, sleep_b, done}, 64'd0);
    check("rst_enosc", 64'(enosc), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_ovf_err", {62'd0, ovf, err}, 64'd0);
    quiet = 1'b1;
    repeat (60) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    check("rst_no_done", 64'(quiet), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
